// File: rtl/conveyor_bank_if.sv
// Conveyor bank access/reserve/writeback/interrupt bundle; slave = conveyor, master = pipeline side.
// Flush signals exist only when CONVEYOR_FLUSH_EN is defined.
interface conveyor_bank_if #(
  parameter int WORD_WIDTH          = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int CTX_WIDTH           = 2,
  parameter int FAULT_ADDR_WIDTH    = 3,
  parameter int WB_PORTS            = 2
);
  logic [CTX_WIDTH-1:0]                     ctx;
  logic                                     access_req;
  logic [CONVEYOR_ADDR_WIDTH-1:0]           access_off;
  logic [WORD_WIDTH-1:0]                    access_value;
  logic [FAULT_ADDR_WIDTH-1:0]              access_fault;
  logic                                     halt;
  logic                                     reserve;
  logic [CONVEYOR_ADDR_WIDTH-1:0]           reserve_slot;
  logic                                     reserve_stall;
  logic [WB_PORTS-1:0]                      wb_valid;
  logic [WB_PORTS*CTX_WIDTH-1:0]            wb_ctx;
  logic [WB_PORTS*CONVEYOR_ADDR_WIDTH-1:0]  wb_slot;
  logic [WB_PORTS*WORD_WIDTH-1:0]           wb_value;
  logic [WB_PORTS*FAULT_ADDR_WIDTH-1:0]     wb_fault;
  logic                                     int_enter;
  logic [CTX_WIDTH-1:0]                     int_ctx;
  logic [WORD_WIDTH-1:0]                    int_value;
  logic [WORD_WIDTH-1:0]                    int_bus;
  logic [CONVEYOR_ADDR_WIDTH:0]             pending;
`ifdef CONVEYOR_FLUSH_EN
  logic                                     flush;
  logic [CTX_WIDTH-1:0]                     flush_ctx;
`endif

  modport slave (
    input  ctx, access_req, access_off, reserve,
    input  wb_valid, wb_ctx, wb_slot, wb_value, wb_fault,
    input  int_enter, int_ctx, int_value, int_bus,
`ifdef CONVEYOR_FLUSH_EN
    input  flush, flush_ctx,
`endif
    output access_value, access_fault, halt, reserve_slot, reserve_stall, pending
  );

  modport master (
    output ctx, access_req, access_off, reserve,
    output wb_valid, wb_ctx, wb_slot, wb_value, wb_fault,
    output int_enter, int_ctx, int_value, int_bus,
`ifdef CONVEYOR_FLUSH_EN
    output flush, flush_ctx,
`endif
    input  access_value, access_fault, halt, reserve_slot, reserve_stall, pending
  );
endinterface

// File: rtl/conveyor_bank.sv
// Multi-context conveyor store: combinational read with writeback forwarding, state updates next edge.
// Reserve stalls at SIZE-2 in flight or on a same-context entry/flush; optional flush via CONVEYOR_FLUSH_EN.
module conveyor_bank #(
  parameter int WORD_WIDTH          = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int CTX_WIDTH           = 2,
  parameter int FAULT_ADDR_WIDTH    = 3,
  parameter int WB_PORTS            = 2
) (
  input logic             clk,
  input logic             reset,
  conveyor_bank_if.slave  bus
);
  localparam int SIZE     = 1 << CONVEYOR_ADDR_WIDTH;
  localparam int CONTEXTS = 1 << CTX_WIDTH;
  localparam int PW       = CONVEYOR_ADDR_WIDTH + 1;

  typedef logic [CONVEYOR_ADDR_WIDTH-1:0] idx_t;
  typedef logic [CTX_WIDTH-1:0]           ctx_t;
  typedef logic [PW-1:0]                  cnt_t;
  typedef struct packed {
    logic                        fin;
    logic [FAULT_ADDR_WIDTH-1:0] flt;
    logic [WORD_WIDTH-1:0]       word;
  } slot_t;

  localparam cnt_t PEND_MAX = cnt_t'(SIZE - 2);
  localparam idx_t ONE      = idx_t'(1);
  localparam idx_t TWO      = idx_t'(2);

  slot_t mem  [CONTEXTS][SIZE];
  idx_t  head [CONTEXTS];
  cnt_t  pend [CONTEXTS];

  ctx_t                        wb_c [WB_PORTS];
  idx_t                        wb_s [WB_PORTS];
  logic [WORD_WIDTH-1:0]       wb_v [WB_PORTS];
  logic [FAULT_ADDR_WIDTH-1:0] wb_f [WB_PORTS];

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_c[p] = bus.wb_ctx[p*CTX_WIDTH +: CTX_WIDTH];
      wb_s[p] = bus.wb_slot[p*CONVEYOR_ADDR_WIDTH +: CONVEYOR_ADDR_WIDTH];
      wb_v[p] = bus.wb_value[p*WORD_WIDTH +: WORD_WIDTH];
      wb_f[p] = bus.wb_fault[p*FAULT_ADDR_WIDTH +: FAULT_ADDR_WIDTH];
    end
  end

  logic flush_go;
  ctx_t flush_c;
`ifdef CONVEYOR_FLUSH_EN
  assign flush_go = bus.flush;
  assign flush_c  = bus.flush_ctx;
`else
  assign flush_go = 1'b0;
  assign flush_c  = '0;
`endif

  // Read path: lowest-index matching writeback port is forwarded as finished.
  idx_t  rd_idx;
  slot_t rd_slot;
  logic  fwd_hit;
  always_comb begin
    rd_idx  = head[bus.ctx] + bus.access_off;
    rd_slot = mem[bus.ctx][rd_idx];
    fwd_hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (!fwd_hit && bus.wb_valid[p] && wb_c[p] == bus.ctx && wb_s[p] == rd_idx) begin
        fwd_hit = 1'b1;
        rd_slot = '{fin: 1'b1, flt: wb_f[p], word: wb_v[p]};
      end
    end
  end

  assign bus.access_value = rd_slot.word;
  assign bus.access_fault = rd_slot.fin ? rd_slot.flt : '0;
  assign bus.halt         = bus.access_req & ~rd_slot.fin;
  assign bus.reserve_slot = head[bus.ctx] - ONE;
  assign bus.pending      = pend[bus.ctx];

  logic ent_go, res_go;
  idx_t ent_s1, ent_s2;
  assign ent_go = bus.int_enter & ~(flush_go & flush_c == bus.int_ctx);
  assign ent_s1 = head[bus.int_ctx] - ONE;
  assign ent_s2 = head[bus.int_ctx] - TWO;

  assign bus.reserve_stall = bus.reserve & ((pend[bus.ctx] == PEND_MAX) |
                                            (bus.int_enter & bus.int_ctx == bus.ctx) |
                                            (flush_go & flush_c == bus.ctx));
  assign res_go = bus.reserve & ~bus.reserve_stall;

  // A port commits only if no lower port hits the same slot, no entry overwrites it,
  // and its context is not being flushed; only committed writes to unfinished slots retire.
  logic [WB_PORTS-1:0] wb_win;
  cnt_t                dec      [CONTEXTS];
  cnt_t                pend_nxt [CONTEXTS];
  cnt_t                sum;
  always_comb begin
    wb_win = '0;
    for (int c = 0; c < CONTEXTS; c++) dec[c] = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_win[p] = bus.wb_valid[p];
      for (int q = 0; q < p; q++) begin
        if (bus.wb_valid[q] && wb_c[q] == wb_c[p] && wb_s[q] == wb_s[p]) wb_win[p] = 1'b0;
      end
      if (ent_go && wb_c[p] == bus.int_ctx && (wb_s[p] == ent_s1 || wb_s[p] == ent_s2))
        wb_win[p] = 1'b0;
      if (flush_go && wb_c[p] == flush_c) wb_win[p] = 1'b0;
      if (wb_win[p] && !mem[wb_c[p]][wb_s[p]].fin) dec[wb_c[p]] = dec[wb_c[p]] + cnt_t'(1);
    end
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < CONTEXTS; c++) begin
      sum = pend[c] + ((res_go && bus.ctx == ctx_t'(c)) ? cnt_t'(1) : cnt_t'(0));
      if (flush_go && flush_c == ctx_t'(c)) pend_nxt[c] = '0;
      else if (dec[c] > sum)                 pend_nxt[c] = '0;
      else                                   pend_nxt[c] = sum - dec[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CONTEXTS; c++) begin
        head[c] <= '0;
        pend[c] <= '0;
        for (int s = 0; s < SIZE; s++) mem[c][s] <= '0;
      end
    end else begin
      for (int c = 0; c < CONTEXTS; c++) begin
        pend[c] <= pend_nxt[c];
        if (flush_go && flush_c == ctx_t'(c)) begin
          for (int s = 0; s < SIZE; s++) mem[c][s].fin <= 1'b0;
        end
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_win[p]) mem[wb_c[p]][wb_s[p]] <= '{fin: 1'b1, flt: wb_f[p], word: wb_v[p]};
      end
      if (res_go) begin
        head[bus.ctx]                   <= bus.reserve_slot;
        mem[bus.ctx][bus.reserve_slot]  <= '0;
      end
      // Entry is applied last so it overrides anything else aimed at its two slots.
      if (ent_go) begin
        head[bus.int_ctx]         <= ent_s2;
        mem[bus.int_ctx][ent_s1]  <= '{fin: 1'b1, flt: '0, word: bus.int_value};
        mem[bus.int_ctx][ent_s2]  <= '{fin: 1'b1, flt: '0, word: bus.int_bus};
      end
    end
  end
endmodule

// File: doc/conveyor_bank.md
Name: conveyor_bank

Overview:
- Multi-context conveyor store; generalises the single-context, single-load conveyor to CONTEXTS interrupt levels and WB_PORTS independent, tagged, out-of-order writeback channels.
- Sits between the decoder (conveyor reads and slot reservation), the load/ALU pipelines (writeback by slot tag) and interrupt control (two-word entry push into the target context).
- Tracks in-flight reservations per context and back-pressures reservation when the conveyor would overrun.

Parameters:
- WORD_WIDTH, 32, data word width.
- CONVEYOR_ADDR_WIDTH, 4, log2 slots per context (SIZE = 1<<CONVEYOR_ADDR_WIDTH).
- CTX_WIDTH, 2, log2 contexts (CONTEXTS = 1<<CTX_WIDTH).
- FAULT_ADDR_WIDTH, 3, fault code width; code 0 = no fault.
- WB_PORTS, 2, number of writeback channels.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ctx  in  CTX_WIDTH  active context for access and reserve.
- access_req  in  1  current instruction reads the conveyor.
- access_off  in  CONVEYOR_ADDR_WIDTH  offset from the active head.
- access_value  out  WORD_WIDTH  word at head+offset.
- access_fault  out  FAULT_ADDR_WIDTH  fault code of the accessed slot.
- halt  out  1  access_req and slot not finished.
- reserve  in  1  allocate a slot in ctx (head decrements).
- reserve_slot  out  CONVEYOR_ADDR_WIDTH  slot returned by reserve (head(ctx)-1).
- reserve_stall  out  1  reserve refused this cycle.
- wb_valid  in  WB_PORTS  per-port writeback strobe.
- wb_ctx  in  WB_PORTS*CTX_WIDTH  per-port target context.
- wb_slot  in  WB_PORTS*CONVEYOR_ADDR_WIDTH  per-port target slot.
- wb_value  in  WB_PORTS*WORD_WIDTH  per-port data.
- wb_fault  in  WB_PORTS*FAULT_ADDR_WIDTH  per-port fault code.
- int_enter  in  1  interrupt entry push.
- int_ctx  in  CTX_WIDTH  context receiving the entry words.
- int_value  in  WORD_WIDTH  written to head-1, finished.
- int_bus  in  WORD_WIDTH  written to head-2, finished.
- pending  out  CONVEYOR_ADDR_WIDTH+1  in-flight count of ctx.

Behaviour:
- Slot = {finished, fault, word}. Reset: every slot of every context {0,0,0}; all heads 0; all pending 0. Outputs follow combinationally from that state (halt = access_req, access_value 0, reserve_stall 0).
- Read (combinational): slot = head(ctx)+access_off, mod SIZE. If any wb_valid port matches (ctx, slot), forward that port's data with finished=1; the lowest-index port wins. halt = access_req & !finished. access_fault = slot fault when finished, else 0.
- Reserve: when reserve & !reserve_stall, next edge sets head(ctx) -= 1, clears slot head-1 to {0,0,0}, and pending(ctx) += 1.
- reserve_stall = reserve & (pending(ctx)==SIZE-2 | (int_enter & int_ctx==ctx)). Two slots stay free for interrupt entry.
- Writeback: each valid port writes {1, wb_fault, wb_value} to (wb_ctx, wb_slot).
  - pending(wb_ctx) decrements only if the slot was unfinished; writes to finished slots overwrite data with no count change.
  - Same-slot collisions within a cycle: the lowest port index wins; only one decrement.
  - Multiple decrements to one context in one cycle are summed.
- Interrupt entry: writes head-1 = {1,0,int_value} and head-2 = {1,0,int_bus} in int_ctx; head(int_ctx) -= 2; pending unchanged.
  - Entry beats a same-cycle writeback to either of those slots.
  - Entry and reserve to the same context: entry wins, reserve stalls.
- Wrap-around: all head and slot arithmetic is modulo SIZE. pending never exceeds SIZE-2 and never underflows.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight writebacks in that cycle are discarded.

Optional Feature:
- CONVEYOR_FLUSH_EN: adds flush (in,1) and flush_ctx (in,CTX_WIDTH).
  - Flush clears every finished bit in flush_ctx and sets its pending to 0 next edge; the head is kept. Writebacks to that context in the same cycle are dropped.
  - Flush beats reserve and int_enter on the same context.
- Without the macro: ports are absent and flush logic is not built.

Test Plan:
- Reset, ctx=0, access_req=1, off=0 -> halt=1, access_value=0, pending=0, reserve_stall=0.
- Reserve in ctx 1 from head 0 -> reserve_slot=15; next cycle pending=1. Then wb port1 (ctx1, slot15, 0xDEADBEEF, fault 0) with access off=0 same cycle -> halt=0, access_value=0xDEADBEEF via forward; next cycle pending=0.
- 14 reserves in ctx 0 -> pending=14, 15th gives reserve_stall=1 and head unchanged. Wb of slot 2 with fault 3 -> access of that slot gives access_fault=3, halt=0.
- int_enter to ctx 2 (head 0), int_value=0x11, int_bus=0x22, with same-cycle reserve ctx 2 -> reserve_stall=1; after edge off=0 reads 0x22, off=1 reads 0x11, pending unchanged.
- Ports 0 and 1 both write ctx0 slot 5 (0xA / 0xB) -> slot holds 0xA, pending drops by exactly 1.
- CONVEYOR_FLUSH_EN: flush ctx 1 with 3 pending and a finished slot -> pending=0, access halts; ctx 0 unaffected.
